// File: rtl/llc_way_select_pkg.sv
// rtl/llc_way_select_pkg.sv - shared line package: way count, PLRU word, op/kind enums
package llc_way_select_pkg;

    localparam int LINE_N_WAY = 16;

    typedef logic [LINE_N_WAY-2:0] plru_word_t;

    typedef enum logic [1:0] {
        OP_LOOKUP    = 2'd0,
        OP_PROBE     = 2'd1,
        OP_CLEAR_SET = 2'd2,
        OP_RSVD      = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        KIND_HIT          = 2'd0,
        KIND_FILL_INVALID = 2'd1,
        KIND_EVICT        = 2'd2,
        KIND_NONE         = 2'd3
    } kind_e;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_one(input logic [15:0] v);
        lowest_one = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) lowest_one = 4'(i);
        end
    endfunction

endpackage

// File: rtl/llc_plru_tree.sv
// rtl/llc_plru_tree.sv - tree-PLRU update and victim walk for one set word
module llc_plru_tree
    import llc_way_select_pkg::*;
#(
    parameter int N_WAY = LINE_N_WAY
) (
    input  logic [N_WAY-2:0] word_in,
    input  logic [3:0]       upd_way,
    output logic [N_WAY-2:0] word_upd,
    output logic [3:0]       victim
);

    localparam int LVL   = $clog2(N_WAY);
    localparam int IDX_W = (N_WAY > 2) ? $clog2(N_WAY - 1) : 1;

    typedef logic [IDX_W-1:0] idx_t;

    // Point every node on the path to upd_way toward it, MSB of the way first.
    always_comb begin
        int node;
        node     = 0;
        word_upd = word_in;
        for (int i = LVL - 1; i >= 0; i--) begin
            word_upd[idx_t'(node)] = upd_way[i];
            node = 2 * node + 1 + int'(upd_way[i]);
        end
    end

    // Follow the side each node does not point to; that leaf is the victim.
    always_comb begin
        int   node;
        logic vb;
        node   = 0;
        vb     = 1'b0;
        victim = '0;
        for (int i = LVL - 1; i >= 0; i--) begin
            vb        = ~word_in[idx_t'(node)];
            victim[i] = vb;
            node      = 2 * node + 1 + int'(vb);
        end
    end

endmodule

// File: rtl/llc_way_select.sv
// rtl/llc_way_select.sv - LLC way selection with per-set tree-PLRU, 2-stage pipeline
module llc_way_select
    import llc_way_select_pkg::*;
#(
    parameter int N_WAY = LINE_N_WAY,
    parameter int N_SET = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [$clog2(N_SET)-1:0] req_set,
    input  logic [N_WAY-1:0]         req_hit,
    input  logic [N_WAY-1:0]         req_vld,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_way,
    output logic [1:0]               rsp_kind,
    output logic                     rsp_err
);

    localparam int SET_W = $clog2(N_SET);

    typedef logic [N_WAY-2:0] word_t;

    word_t              plru_mem [N_SET];

    logic               s2_valid;
    logic               s2_done;
    op_e                s2_op;
    logic [SET_W-1:0]   s2_set;
    logic [N_WAY-1:0]   s2_hit;
    logic [N_WAY-1:0]   s2_vld;
    word_t              s2_word;

    logic               accept;
    logic [N_WAY-1:0]   inv_vec;
    logic [3:0]         victim;
    logic [3:0]         sel_way;
    kind_e              sel_kind;
    logic               multi_hit;
    logic               plru_we;
    word_t              word_upd;
    word_t              wr_word;
    word_t              rd_word;

    assign req_ready = !s2_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign inv_vec   = ~s2_vld;

    llc_plru_tree #(.N_WAY(N_WAY)) u_tree (
        .word_in  (s2_word),
        .upd_way  (sel_way),
        .word_upd (word_upd),
        .victim   (victim)
    );

    // Pick the way: lowest hit, else lowest invalid, else the PLRU victim.
    always_comb begin
        sel_way  = 4'd0;
        sel_kind = KIND_NONE;
        if (s2_op != OP_CLEAR_SET) begin
            if (|s2_hit) begin
                sel_way  = lowest_one(16'(s2_hit));
                sel_kind = KIND_HIT;
            end else if (|inv_vec) begin
                sel_way  = lowest_one(16'(inv_vec));
                sel_kind = KIND_FILL_INVALID;
            end else begin
                sel_way  = victim;
                sel_kind = KIND_EVICT;
            end
        end
    end

    // Write once, in the first valid cycle; probes leave the word alone.
    always_comb begin
        multi_hit = |(s2_hit & (s2_hit - N_WAY'(1)));
        plru_we   = s2_valid && !s2_done && (s2_op == OP_LOOKUP || s2_op == OP_CLEAR_SET);
        wr_word   = (s2_op == OP_CLEAR_SET) ? '0 : word_upd;
        rd_word   = (plru_we && (s2_set == req_set)) ? wr_word : plru_mem[req_set];
    end

    assign rsp_valid = s2_valid;
    assign rsp_way   = s2_valid ? sel_way : 4'd0;
    assign rsp_kind  = s2_valid ? sel_kind : KIND_NONE;
    assign rsp_err   = s2_valid && multi_hit;

    // Stage register: capture the request and its (forwarded) PLRU word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_done  <= 1'b0;
            s2_op    <= OP_LOOKUP;
            s2_set   <= '0;
            s2_hit   <= '0;
            s2_vld   <= '0;
            s2_word  <= '0;
        end else begin
            if (req_ready) begin
                s2_valid <= req_valid;
                s2_done  <= 1'b0;
            end else begin
                s2_done  <= 1'b1;
            end
            if (accept) begin
                s2_op   <= op_e'(req_op);
                s2_set  <= req_set;
                s2_hit  <= req_hit;
                s2_vld  <= req_vld;
                s2_word <= rd_word;
            end
        end
    end

    // PLRU storage, one word per set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SET; i++) plru_mem[i] <= '0;
        end else if (plru_we) begin
            plru_mem[s2_set] <= wr_word;
        end
    end

endmodule

// File: tb/tb_llc_way_select.sv
// tb/tb_llc_way_select.sv - randomized self-checking bench for llc_way_select
module tb_llc_way_select;
    import llc_way_select_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [5:0]  req_set = 6'd0;
    logic [15:0] req_hit = 16'd0;
    logic [15:0] req_vld = 16'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [3:0]  rsp_way;
    logic [1:0]  rsp_kind;
    logic        rsp_err;

    always #5 clk = ~clk;

    llc_way_select #(.N_WAY(16), .N_SET(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_set   (req_set),
        .req_hit   (req_hit),
        .req_vld   (req_vld),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_way   (rsp_way),
        .rsp_kind  (rsp_kind),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [3:0] way;
        logic [1:0] kind;
        logic       err;
    } rsp_t;

    int          n_checks = 0;
    int          n_fail = 0;
    plru_word_t  mdl [64];
    rsp_t        exp_q [$];
    bit          pending = 1'b0;
    logic [3:0]  last_way = 4'd0;
    logic [1:0]  last_kind = 2'd0;
    logic        last_err = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] first_idx(input logic [15:0] v, input bit want);
        for (int i = 0; i < 16; i++) begin
            if (v[i] == want) return 4'(i);
        end
        return 4'd0;
    endfunction

    // Leaf reached by always taking the side a node does not point to.
    function automatic logic [3:0] mdl_victim(input plru_word_t w);
        int node = 0;
        int way = 0;
        int b;
        for (int l = 0; l < 4; l++) begin
            b    = w[node] ? 0 : 1;
            way  = way * 2 + b;
            node = 2 * node + 1 + b;
        end
        return 4'(way);
    endfunction

    function automatic plru_word_t mdl_touch(input plru_word_t w, input logic [3:0] way);
        int node = 0;
        int b;
        for (int l = 3; l >= 0; l--) begin
            b       = way[l] ? 1 : 0;
            w[node] = way[l];
            node    = 2 * node + 1 + b;
        end
        return w;
    endfunction

    task automatic mdl_apply(input logic [1:0] op, input logic [5:0] set,
                             input logic [15:0] hit, input logic [15:0] vld, output rsp_t r);
        r.err = ($countones(hit) > 1);
        if (op == 2'd2) begin
            r.way  = 4'd0;
            r.kind = 2'd3;
            mdl[set] = '0;
        end else begin
            if (hit != 16'd0) begin
                r.way  = first_idx(hit, 1'b1);
                r.kind = 2'd0;
            end else if (vld != 16'hFFFF) begin
                r.way  = first_idx(vld, 1'b0);
                r.kind = 2'd1;
            end else begin
                r.way  = mdl_victim(mdl[set]);
                r.kind = 2'd2;
            end
            if (op == 2'd0) mdl[set] = mdl_touch(mdl[set], r.way);
        end
    endtask

    task automatic monitor();
        rsp_t e;
        if (pending) chk("rsp_latency", rsp_valid, 1);
        chk("req_ready_rule", req_ready, !rsp_valid || rsp_ready);
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_rsp", rsp_valid, 0);
            end else begin
                e = exp_q[0];
                chk("rsp_way", rsp_way, e.way);
                chk("rsp_kind", rsp_kind, e.kind);
                chk("rsp_err", rsp_err, e.err);
                if (rsp_ready) begin
                    last_way  = rsp_way;
                    last_kind = rsp_kind;
                    last_err  = rsp_err;
                    void'(exp_q.pop_front());
                end
            end
        end
        pending = req_valid && req_ready;
        if (pending) begin
            mdl_apply(req_op, req_set, req_hit, req_vld, e);
            exp_q.push_back(e);
        end
    endtask

    task automatic cyc(input bit v, input logic [1:0] op, input logic [5:0] set,
                       input logic [15:0] hit, input logic [15:0] vld, input bit rr);
        req_valid = v;
        req_op    = op;
        req_set   = set;
        req_hit   = hit;
        req_vld   = vld;
        rsp_ready = rr;
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 6'd0, 16'd0, 16'hFFFF, 1'b1);
    endtask

    task automatic do_reset();
        int nz = 0;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #2;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_way", rsp_way, 0);
        chk("rst_rsp_kind", rsp_kind, 3);
        chk("rst_rsp_err", rsp_err, 0);
        for (int i = 0; i < 64; i++) if (dut.plru_mem[i] != '0) nz++;
        chk("rst_plru_zero", nz, 0);
        for (int i = 0; i < 64; i++) mdl[i] = '0;
        exp_q.delete();
        pending = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit         v;
        bit         rr;
        logic [1:0] op;
        logic [5:0] set;
        logic [15:0] hit;
        logic [15:0] vld;

        #1;
        do_reset();

        cyc(1'b1, 2'd0, 6'd3, 16'h0000, 16'hFFFF, 1'b1);
        idle(1);
        chk("evict_fresh_kind", last_kind, 2);
        chk("evict_fresh_way", last_way, 15);

        cyc(1'b1, 2'd0, 6'd5, 16'h8000, 16'hFFFF, 1'b1);
        idle(1);
        chk("hit15_kind", last_kind, 0);
        chk("hit15_way", last_way, 15);
        cyc(1'b1, 2'd0, 6'd5, 16'h0000, 16'hFFFF, 1'b1);
        idle(1);
        chk("evict_after_hit_kind", last_kind, 2);
        chk("evict_after_hit_way", last_way, 7);

        cyc(1'b1, 2'd0, 6'd7, 16'h0000, 16'hFFF7, 1'b1);
        idle(1);
        chk("fill_kind", last_kind, 1);
        chk("fill_way", last_way, 3);
        cyc(1'b1, 2'd1, 6'd7, 16'h0000, 16'hFFFF, 1'b1);
        idle(1);
        chk("probe_kind", last_kind, 2);
        chk("probe_way", last_way, 15);
        chk("probe_no_write", dut.plru_mem[7], 15'h0108);

        cyc(1'b1, 2'd0, 6'd8, 16'h0011, 16'hFFFF, 1'b1);
        idle(1);
        chk("multihit_kind", last_kind, 0);
        chk("multihit_way", last_way, 0);
        chk("multihit_err", last_err, 1);

        cyc(1'b1, 2'd0, 6'd10, 16'h8000, 16'hFFFF, 1'b1);
        cyc(1'b1, 2'd0, 6'd10, 16'h0000, 16'hFFFF, 1'b1);
        chk("b2b_first_way", last_way, 15);
        idle(1);
        chk("b2b_fwd_kind", last_kind, 2);
        chk("b2b_fwd_way", last_way, 7);

        cyc(1'b1, 2'd2, 6'd5, 16'h0000, 16'hFFFF, 1'b1);
        idle(1);
        chk("clear_kind", last_kind, 3);
        chk("clear_word", dut.plru_mem[5], 15'h0000);

        cyc(1'b1, 2'd0, 6'd9, 16'h0100, 16'hFFFF, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 2'd0, 6'd9, 16'h0000, 16'hFFFF, 1'b0);
            chk("stall_req_ready", req_ready, 0);
            chk("stall_way", rsp_way, 8);
            chk("stall_valid", rsp_valid, 1);
        end
        chk("stall_plru", dut.plru_mem[9], mdl[9]);
        do_reset();

        cyc(1'b1, 2'd0, 6'd12, 16'h0004, 16'hFFFF, 1'b1);
        do_reset();
        chk("dropped_write", dut.plru_mem[12], 15'h0000);

        for (int c = 0; c < 3000; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            rr  = ($urandom_range(0, 9) < 7);
            op  = 2'($urandom_range(0, 3));
            set = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0, 1: hit = 16'h0000;
                2:    hit = 16'h0001 << $urandom_range(0, 15);
                default: hit = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            endcase
            vld = ($urandom_range(0, 2) != 0) ? 16'hFFFF : (16'hFFFF & ~(16'h0001 << $urandom_range(0, 15)));
            cyc(v, op, set, hit, vld, rr);
        end
        idle(3);
        chk("drained", exp_q.size(), 0);
        for (int i = 0; i < 64; i++) chk($sformatf("plru_final_%0d", i), dut.plru_mem[i], mdl[i]);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/llc_way_select.md
LLC_WAY_SELECT -- requirements
Module: llc_way_select

Interface
REQ-001 SHALL have parameter N_WAY, default 16, meaning ways per set, a power of two from 2 to 16.
REQ-002 SHALL have parameter N_SET, default 64, meaning sets held, a power of two.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted when req_valid and req_ready are both high.
REQ-007 SHALL have port req_op, input, 2 bits: 0 LOOKUP, 1 PROBE, 2 CLEAR_SET, 3 reserved (treated as PROBE).
REQ-008 SHALL have port req_set, input, log2(N_SET) bits: set index.
REQ-009 SHALL have port req_hit, input, N_WAY bits: tag-match vector.
REQ-010 SHALL have port req_vld, input, N_WAY bits: line-valid vector.
REQ-011 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-012 SHALL have port rsp_ready, input, 1 bit: response consumed when rsp_valid and rsp_ready are both high.
REQ-013 SHALL have port rsp_way, output, 4 bits: selected way.
REQ-014 SHALL have port rsp_kind, output, 2 bits: 0 HIT, 1 FILL_INVALID, 2 EVICT, 3 NONE.
REQ-015 SHALL have port rsp_err, output, 1 bit: req_hit was multi-hot.

Function
REQ-016 SHALL hold N_SET PLRU words of N_WAY-1 bits in flops, as a binary tree with root node 0.
REQ-017 SHALL, on update for way w, write node bits MSB-first: bit = w[i]; next node = 2n+2 if the bit is 1, else 2n+1.
REQ-018 SHALL compute the victim as: v[i] = NOT bit[n]; next node = 2n+2 if v[i] is 1, else 2n+1.
REQ-019 SHALL be a 2-stage pipeline: S1 accepts the request and reads the set's PLRU word; S2 selects the way, writes PLRU and drives the response. Latency is 1 cycle from acceptance to rsp_valid.
REQ-020 SHALL tie req_ready = !rsp_valid || rsp_ready. A stalled response holds all rsp_* stable and blocks acceptance.
REQ-021 SHALL handle LOOKUP with any hit: rsp_way is the lowest set hit index, rsp_kind HIT, PLRU updated to that way.
REQ-022 SHALL handle LOOKUP with no hit and any invalid way: rsp_way is the lowest index with req_vld 0, rsp_kind FILL_INVALID, PLRU updated.
REQ-023 SHALL handle LOOKUP with no hit and all ways valid: rsp_way is the PLRU victim, rsp_kind EVICT, PLRU updated to the victim.
REQ-024 SHALL handle PROBE: report as for LOOKUP but never write PLRU.
REQ-025 SHALL handle CLEAR_SET: write the set's PLRU word to all zeros, rsp_kind NONE, rsp_way 0.
REQ-026 SHALL assert rsp_err when req_hit has more than one bit set; processing is otherwise per REQ-021.
REQ-027 SHALL write PLRU exactly once per accepted request, on the cycle the response first goes valid. A stall SHALL NOT repeat the write.
REQ-028 SHALL forward: when the S1 set equals the set written by S2 in the same cycle, S1 uses the written word. Back-to-back same-set requests therefore see updates in order.
REQ-029 SHALL ignore req_hit and req_vld bits at or above N_WAY.

Reset
REQ-030 SHALL, on rst_n low and asynchronously, clear all PLRU words to 0, rsp_valid to 0, rsp_way to 0, rsp_kind to NONE and rsp_err to 0.
REQ-031 SHALL drop an in-flight request on reset mid-operation: no response and no PLRU write.
REQ-032 SHALL drive req_ready 1 in the first cycle after rst_n rises.

Structure
REQ-033 SHALL take N_WAY from the shared line package, and that package SHALL hold the op and kind enums and the PLRU word typedef.
REQ-034 SHALL contain one combinational sub-module, llc_plru_tree, that computes the next PLRU word for a given way and the victim way from a PLRU word.

Verification
REQ-035 SHALL cover: after reset, LOOKUP on set 3 with hit 0 and vld all ones -> EVICT, way 15.
REQ-036 SHALL cover: after reset, LOOKUP on set 5 with hit 0x8000 -> HIT, way 15; then LOOKUP on set 5 with no hit and all valid -> EVICT, way 7.
REQ-037 SHALL cover: LOOKUP with vld 0xFFF7 and no hit -> FILL_INVALID, way 3; a following PROBE on the same set -> EVICT, and the PLRU word is unchanged.
REQ-038 SHALL cover: hit 0x0011 -> HIT, way 0, rsp_err 1.
REQ-039 SHALL cover: two back-to-back same-set LOOKUPs, hitting way 15 then missing with all valid -> second response is EVICT, way 7 (forwarding).
REQ-040 SHALL cover: rsp_ready held low for 3 cycles -> response stable, req_ready 0, one PLRU write; rst_n pulsed mid-stall -> rsp_valid 0 and all PLRU words 0.
